// File: rtl/deseg_pkg.sv
// Shared definitions for the hop de-segmenter: output FSM encoding and the
// parameter legality check used at elaboration.
package deseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Hop index must address every hop sample, the hop must fit in a segment,
  // and the segment counter must be able to represent SEG_SIZE exactly.
  function automatic bit params_legal(input int awidth, input int hawidth,
                                      input int seg_size, input int shift_size);
    return (shift_size > 0) &&
           ((1 << hawidth) >= shift_size) &&
           (shift_size <= seg_size) &&
           ((1 << awidth) > seg_size);
  endfunction

endpackage

// File: rtl/deseg_hop_buf.sv
// Ping-pong hop storage: two banks of 2^HAWIDTH words, addressed as {bank, idx}.
// One synchronous write port, one asynchronous read port.
module deseg_hop_buf
  #(parameter int BWIDTH  = 16,
    parameter int HAWIDTH = 4)
  (input  logic              clk,
   input  logic              we,
   input  logic [HAWIDTH:0]  waddr,
   input  logic [BWIDTH-1:0] wdata,
   input  logic [HAWIDTH:0]  raddr,
   output logic [BWIDTH-1:0] rdata);

  logic [BWIDTH-1:0] mem [2**(HAWIDTH+1)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/deseg_hop_stream.sv
// Rebuilds a chronological sample stream from newest-first segments by keeping
// the SHIFT_SIZE newest samples of each. Optional length check: DESEG_LEN_CHECK_EN.
//
// Output handshake: a sample transfers on a rising edge where y_valid & y_ready;
// once raised, y_valid and y_o hold unchanged until that transfer happens.
module deseg_hop_stream
  import deseg_pkg::*;
  #(parameter int BWIDTH     = 16,
    parameter int AWIDTH     = 9,
    parameter int HAWIDTH    = 4,
    parameter int SEG_SIZE   = 420,
    parameter int SHIFT_SIZE = 12)
  (input  logic              clk,
   input  logic              reset,
   input  logic [BWIDTH-1:0] x_i,
   input  logic              load,
   input  logic              done,
   output logic [BWIDTH-1:0] y_o,
   output logic              y_valid,
   input  logic              y_ready,
   output logic              overflow,
   output logic              seg_err,
   output state_t            dbg_state);

  if (!params_legal(AWIDTH, HAWIDTH, SEG_SIZE, SHIFT_SIZE)) begin : g_bad_params
    $error("deseg_hop_stream: illegal AWIDTH/HAWIDTH/SEG_SIZE/SHIFT_SIZE combination");
  end

  localparam logic [AWIDTH-1:0]  CNT_MAX  = '1;
  localparam logic [AWIDTH-1:0]  SHIFT_A  = AWIDTH'(SHIFT_SIZE);
  localparam logic [HAWIDTH-1:0] LAST_IDX = HAWIDTH'(SHIFT_SIZE - 1);
`ifdef DESEG_LEN_CHECK_EN
  localparam logic [AWIDTH-1:0]  SEG_A    = AWIDTH'(SEG_SIZE);
`endif

  logic [AWIDTH-1:0]  in_cnt;
  logic               wbank;
  logic               rbank;
  logic               drop;
  logic [1:0]         full;
  logic               pend_q;
  logic [HAWIDTH-1:0] rd_idx;
  state_t             state;

  logic               first_hit;
  logic               wr_en;
  logic               len_ok;
  logic               commit;
  logic               release_bank;
  logic [HAWIDTH-1:0] wr_idx;
  logic [HAWIDTH-1:0] rd_sel;
  logic [BWIDTH-1:0]  rd_data;

  always_comb begin
    // Drop decision looks only at the registered flag, so a bank freed on this
    // very edge still counts as full.
    first_hit = load && !done && (in_cnt == '0) && full[wbank];
    wr_en     = load && !done && !drop && !first_hit && (in_cnt < SHIFT_A);
    wr_idx    = LAST_IDX - HAWIDTH'(in_cnt);
`ifdef DESEG_LEN_CHECK_EN
    len_ok    = (in_cnt == SEG_A);
`else
    len_ok    = (in_cnt >= SHIFT_A);
`endif
    commit       = done && (in_cnt != '0) && !drop && len_ok;
    release_bank = (state == ST_EMIT) && y_ready && (rd_idx == LAST_IDX);
    rd_sel       = (state == ST_EMIT) ? rd_idx + HAWIDTH'(1) : '0;
  end

  deseg_hop_buf #(.BWIDTH(BWIDTH), .HAWIDTH(HAWIDTH)) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wbank, wr_idx}),
    .wdata (x_i),
    .raddr ({rbank, rd_sel}),
    .rdata (rd_data)
  );

  // Segment intake: counting, drop tracking and bank commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_cnt   <= '0;
      wbank    <= 1'b0;
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= first_hit;
      if (done) begin
        if (commit) wbank <= ~wbank;
        in_cnt <= '0;
        drop   <= 1'b0;
      end else if (load) begin
        if (first_hit) drop <= 1'b1;
        if (in_cnt != CNT_MAX) in_cnt <= in_cnt + AWIDTH'(1);
      end
    end
  end

`ifdef DESEG_LEN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) seg_err <= 1'b0;
    else       seg_err <= done && (in_cnt != '0) && (in_cnt != SEG_A);
  end
`else
  assign seg_err = 1'b0;
`endif

  // Commit and release always target different banks, so both may land together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      if (commit)       full[wbank] <= 1'b1;
      if (release_bank) full[rbank] <= 1'b0;
    end
  end

  // pend_q delays visibility of a freshly committed bank by one cycle, so the
  // first sample appears on the second edge after the committing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      rbank   <= 1'b0;
      rd_idx  <= '0;
      y_o     <= '0;
      y_valid <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      pend_q <= full[rbank];
      case (state)
        ST_IDLE: begin
          if (full[rbank] && pend_q) begin
            y_o     <= rd_data;
            y_valid <= 1'b1;
            rd_idx  <= '0;
            state   <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (y_ready) begin
            if (rd_idx == LAST_IDX) begin
              y_valid <= 1'b0;
              rbank   <= ~rbank;
              state   <= ST_GAP;
            end else begin
              rd_idx <= rd_idx + HAWIDTH'(1);
              y_o    <= rd_data;
            end
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_deseg_hop_stream.sv
// Self-checking bench for deseg_hop_stream: vector table, hand sequences for
// latency/overflow/reset, and randomized segments against a hop-queue model.
`timescale 1ns/1ps
module tb_deseg_hop_stream;
  import deseg_pkg::*;

  localparam int BW  = 16;
  localparam int SEG = 420;
  localparam int SH  = 12;
  localparam int CNT_SAT = 511;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] x_i = '0;
  logic          load = 1'b0;
  logic          done = 1'b0;
  logic          y_ready = 1'b0;
  logic [BW-1:0] y_o;
  logic          y_valid;
  logic          overflow;
  logic          seg_err;
  state_t        dbg_state;

  deseg_hop_stream dut (
    .clk(clk), .reset(reset), .x_i(x_i), .load(load), .done(done),
    .y_o(y_o), .y_valid(y_valid), .y_ready(y_ready),
    .overflow(overflow), .seg_err(seg_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- reference model / scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] m_seg[$];
  int  m_cnt = 0, m_pending = 0, m_out = 0;
  bit  m_drop = 0, m_ok;
  bit  exp_ovf = 0, exp_err = 0, hold_chk = 0;
  logic [BW-1:0] hold_val;
  int  n_out = 0, n_ovf = 0, n_err = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete(); m_seg.delete();
      m_cnt = 0; m_drop = 0; m_pending = 0; m_out = 0;
      exp_ovf = 0; exp_err = 0; hold_chk = 0;
    end else begin
      chk("overflow pulse", overflow, exp_ovf);
      chk("seg_err pulse", seg_err, exp_err);
      n_ovf += int'(overflow);
      n_err += int'(seg_err);
      if (hold_chk) begin
        chk("hold y_valid", y_valid, 1);
        chk("hold y_o", y_o, hold_val);
      end
      exp_ovf = 0; exp_err = 0;
      // input side for the coming edge; pending hops counted before any free
      if (done) begin
        if (m_cnt != 0) begin
`ifdef DESEG_LEN_CHECK_EN
          m_ok = !m_drop && (m_cnt == SEG);
          exp_err = (m_cnt != SEG);
`else
          m_ok = !m_drop && (m_cnt >= SH);
`endif
          if (m_ok) begin
            for (int i = SH - 1; i >= 0; i--) exp_q.push_back(m_seg[i]);
            m_pending++;
          end
        end
        m_cnt = 0; m_drop = 0; m_seg.delete();
      end else if (load) begin
        if (m_cnt == 0 && m_pending == 2) begin
          m_drop = 1; exp_ovf = 1;
        end
        if (m_cnt < SH) m_seg.push_back(x_i);
        if (m_cnt < CNT_SAT) m_cnt++;
      end
      // output side
      if (y_valid && y_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected output: got %0d, expected no sample", y_o);
        end else begin
          chk("y_o order", y_o, exp_q.pop_front());
        end
        m_out++;
        if (m_out == SH) begin m_out = 0; m_pending--; end
      end
      hold_chk = y_valid && !y_ready;
      hold_val = y_o;
    end
  end

  // ---------------- downstream ready driver ----------------
  int rmode = 0;   // 0 always, 1 pattern 1,0,0, 2 random, 3 never
  int rcnt = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0: y_ready = 1'b1;
      1: y_ready = (rcnt % 3 == 0);
      2: y_ready = 1'($urandom_range(0, 1));
      default: y_ready = 1'b0;
    endcase
    rcnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_seg(input int base, input int len, input int pause_every, input bit load_on_done);
    for (int k = 0; k < len; k++) begin
      if (pause_every > 0 && k > 0 && k % pause_every == 0) begin
        load = 1'b0;
        repeat (3) tick();
      end
      load = 1'b1;
      x_i  = BW'(base + k);
      tick();
    end
    load = load_on_done;
    x_i  = BW'($urandom);
    done = 1'b1;
    tick();
    done = 1'b0;
    load = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    repeat (4) tick();
    while ((exp_q.size() != 0 || y_valid) && n < 3000) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s drain: timed out with %0d samples, expected 0 left", name, exp_q.size());
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int base; int len; int pause; int rmode; int exp_outs; int exp_err;
  } vec_t;
  vec_t vt[7];

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int o0, e0, v0, cnt;
    vt[0] = '{1000, SEG, 0,  0, SH, 0};   // basic hop
    vt[1] = '{1000, SEG, 50, 0, SH, 0};   // paused input
    vt[2] = '{1000, SEG, 0,  1, SH, 0};   // backpressure 1,0,0
    vt[6] = '{9000, SEG, 7,  2, SH, 0};   // pauses + random ready
`ifdef DESEG_LEN_CHECK_EN
    vt[3] = '{1000, SEG-1, 0, 0, 0, 1};   // length error
    vt[4] = '{7000, SH,    0, 2, 0, 1};   // minimum hop length
    vt[5] = '{8000, SH-1,  0, 0, 0, 1};   // shorter than a hop
`else
    vt[3] = '{1000, SEG-1, 0, 0, SH, 0};
    vt[4] = '{7000, SH,    0, 2, SH, 0};
    vt[5] = '{8000, SH-1,  0, 0, 0, 0};
`endif

    // reset state
    repeat (2) tick();
    chk("reset y_o", y_o, 0);
    chk("reset y_valid", y_valid, 0);
    chk("reset overflow", overflow, 0);
    chk("reset seg_err", seg_err, 0);
    reset = 1'b0;
    tick();

    // latency and back-to-back throughput
    rmode = 0;
    send_seg(1000, SEG, 0, 0);
    chk("latency edge0 y_valid", y_valid, 0);
    tick();
    chk("latency edge1 y_valid", y_valid, 0);
    tick();
    chk("latency edge2 y_valid", y_valid, 1);
    chk("latency edge2 y_o", y_o, 1011);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (y_valid) cnt++;
      tick();
    end
    chk("valid run length", cnt, SH);
    wait_drain("latency");

    for (int i = 0; i < 7; i++) begin
      rmode = vt[i].rmode;
      o0 = n_out; e0 = n_err; v0 = n_ovf;
      send_seg(vt[i].base, vt[i].len, vt[i].pause, 0);
      wait_drain($sformatf("vec%0d", i));
      chk($sformatf("vec%0d outputs", i), n_out - o0, vt[i].exp_outs);
      chk($sformatf("vec%0d seg_err", i), n_err - e0, vt[i].exp_err);
      chk($sformatf("vec%0d overflow", i), n_ovf - v0, 0);
    end

    // overflow: third segment dropped while both banks are held
    rmode = 3;
    o0 = n_out; v0 = n_ovf;
    send_seg(1000, SEG, 0, 0);
    send_seg(2000, SEG, 0, 0);
    send_seg(3000, SEG, 0, 0);
    repeat (5) tick();
    chk("overflow count", n_ovf - v0, 1);
    rmode = 0;
    wait_drain("overflow");
    chk("overflow outputs", n_out - o0, 2 * SH);
    for (int i = 0; i < 20; i++) begin
      chk("idle after drain", y_valid, 0);
      tick();
    end

    // lone done is a no-op
    e0 = n_err; o0 = n_out;
    done = 1'b1; tick(); done = 1'b0;
    repeat (5) tick();
    chk("lone done seg_err", n_err - e0, 0);
    chk("lone done outputs", n_out - o0, 0);

    // reset in the middle of a hop
    rmode = 0;
    send_seg(1000, SEG, 0, 0);
    cnt = 0;
    while (!y_valid && cnt < 10) begin tick(); cnt++; end
    chk("pre-reset y_valid", y_valid, 1);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("mid reset y_o", y_o, 0);
    chk("mid reset y_valid", y_valid, 0);
    chk("mid reset overflow", overflow, 0);
    chk("mid reset seg_err", seg_err, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    o0 = n_out;
    send_seg(5000, SEG, 0, 0);
    wait_drain("post reset");
    chk("post reset outputs", n_out - o0, SH);

    // randomized segments, pauses, lengths and downstream stalls
    rmode = 2;
    for (int s = 0; s < 12; s++) begin
      int len, pause;
      len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, SEG + 4)) : SEG;
      pause = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20, 120)) : 0;
      send_seg(int'($urandom_range(0, 60000)), len, pause, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 30)) tick();
      if ($urandom_range(0, 4) == 0) begin
        done = 1'b1; tick(); done = 1'b0;
      end
    end
    rmode = 0;
    wait_drain("random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
